// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the I-cache (port 0) and D-cache (port 1)
// with round-robin request issue, locked write-data bursts and in-order read routing.
`default_nettype none

module mem_arbiter #(
   parameter int ADDR_BITS   = 28,
   parameter int DATA_BITS   = 128,
   parameter int BEATS       = 4,
   parameter int OUTSTANDING = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req0_val,
   output logic                   req0_rdy,
   input  logic [ADDR_BITS-1:0]   req0_addr,
   input  logic                   req0_rw,
   input  logic                   req0_data_valid,
   output logic                   req0_data_ready,
   input  logic [DATA_BITS-1:0]   req0_data_bits,
   input  logic [DATA_BITS/8-1:0] req0_data_mask,
   output logic                   req0_resp_val,
   output logic [DATA_BITS-1:0]   req0_resp_data,
   input  logic                   req1_val,
   output logic                   req1_rdy,
   input  logic [ADDR_BITS-1:0]   req1_addr,
   input  logic                   req1_rw,
   input  logic                   req1_data_valid,
   output logic                   req1_data_ready,
   input  logic [DATA_BITS-1:0]   req1_data_bits,
   input  logic [DATA_BITS/8-1:0] req1_data_mask,
   output logic                   req1_resp_val,
   output logic [DATA_BITS-1:0]   req1_resp_data,
   output logic                   mem_req_val,
   input  logic                   mem_req_rdy,
   output logic [ADDR_BITS-1:0]   mem_req_addr,
   output logic                   mem_req_rw,
   output logic                   mem_req_data_valid,
   input  logic                   mem_req_data_ready,
   output logic [DATA_BITS-1:0]   mem_req_data_bits,
   output logic [DATA_BITS/8-1:0] mem_req_data_mask,
   input  logic                   mem_resp_val,
   input  logic [DATA_BITS-1:0]   mem_resp_data,
   output logic                   resp_err
);

   localparam int PW = $clog2(OUTSTANDING);
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, WDATA = 1'b1} state_t;

   state_t                 state, state_n;
   logic                   prio;
   logic                   lock;
   logic [BW-1:0]          wbeat;
   logic [BW-1:0]          rbeat;
   logic [OUTSTANDING-1:0] owner;
   logic [PW:0]            wr_ptr, rd_ptr;

   logic fifo_empty, fifo_full, head;
   logic elig0, elig1, winner, winner_rw;
   logic fire, data_fire, push, pop, resp_hit;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head       = owner[rd_ptr[PW-1:0]];

   // Outputs are gated by reset so they read 0 the instant reset asserts.
   assign elig0     = reset && (state == IDLE) && req0_val && (req0_rw || !fifo_full);
   assign elig1     = reset && (state == IDLE) && req1_val && (req1_rw || !fifo_full);
   assign winner    = (elig0 && elig1) ? prio : elig1;
   assign winner_rw = winner ? req1_rw : req0_rw;
   assign fire      = mem_req_val && mem_req_rdy;
   assign data_fire = mem_req_data_valid && mem_req_data_ready;
   assign push      = fire && !winner_rw;
   assign resp_hit  = reset && mem_resp_val && !fifo_empty;
   assign pop       = resp_hit && (rbeat == LAST_BEAT);

   assign req0_resp_val  = resp_hit && !head;
   assign req1_resp_val  = resp_hit && head;
   assign req0_resp_data = req0_resp_val ? mem_resp_data : '0;
   assign req1_resp_data = req1_resp_val ? mem_resp_data : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n            = state;
      mem_req_val        = 1'b0;
      mem_req_addr       = '0;
      mem_req_rw         = 1'b0;
      req0_rdy           = 1'b0;
      req1_rdy           = 1'b0;
      mem_req_data_valid = 1'b0;
      mem_req_data_bits  = '0;
      mem_req_data_mask  = '0;
      req0_data_ready    = 1'b0;
      req1_data_ready    = 1'b0;
      case (state)
         IDLE: begin
            mem_req_val = elig0 || elig1;
            if (mem_req_val) begin
               mem_req_addr = winner ? req1_addr : req0_addr;
               mem_req_rw   = winner_rw;
               req0_rdy     = mem_req_rdy && !winner;
               req1_rdy     = mem_req_rdy && winner;
            end
            if (fire && winner_rw) state_n = WDATA;
         end
         WDATA: begin
            mem_req_data_valid = lock ? req1_data_valid : req0_data_valid;
            mem_req_data_bits  = lock ? req1_data_bits  : req0_data_bits;
            mem_req_data_mask  = lock ? req1_data_mask  : req0_data_mask;
            req0_data_ready    = !lock && mem_req_data_ready;
            req1_data_ready    = lock && mem_req_data_ready;
            if (data_fire && (wbeat == LAST_BEAT)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio     <= 1'b0;
         lock     <= 1'b0;
         wbeat    <= '0;
         rbeat    <= '0;
         owner    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         resp_err <= 1'b0;
      end else begin
         if (fire) begin
            prio <= ~winner;
            if (winner_rw) begin
               lock  <= winner;
               wbeat <= '0;
            end
         end
         if (data_fire) wbeat <= wbeat + BW'(1);
         if (push) begin
            owner[wr_ptr[PW-1:0]] <= winner;
            wr_ptr                <= wr_ptr + (PW+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (PW+1)'(1);
            rbeat  <= '0;
         end else if (resp_hit) begin
            rbeat <= rbeat + BW'(1);
         end
         // A beat with no recorded owner is dropped and latched as an error.
         if (mem_resp_val && fifo_empty) resp_err <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between two cache requesters: port 0 is the instruction cache, port 1 is the data cache.
- Arbitrates request issue with round-robin priority.
- Holds the memory write-data channel for the full beat count of a granted write.
- Returns read response beats to the correct requester using an in-order owner FIFO.
- Sits between the two cache instances and the memory interface at the top of the CPU.

Parameters:
ADDR_BITS, 28, memory line address width (mem_req_addr)
DATA_BITS, 128, memory data beat width (`MEM_DATA_BITS)
BEATS, 4, data beats per read response and per write transaction
OUTSTANDING, 4, owner FIFO depth = max in-flight reads; power of 2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
reqN_val  in  1  (N=0,1) requester N request valid
reqN_rdy  out  1  request accepted this cycle when reqN_val&reqN_rdy
reqN_addr  in  ADDR_BITS  line address
reqN_rw  in  1  1=write, 0=read
reqN_data_valid  in  1  write beat valid
reqN_data_ready  out  1  write beat accepted
reqN_data_bits  in  DATA_BITS  write beat
reqN_data_mask  in  DATA_BITS/8  byte mask
reqN_resp_val  out  1  read beat to requester N
reqN_resp_data  out  DATA_BITS  read beat data
mem_req_val/rdy/addr/rw  out/in/out/out  1/1/ADDR_BITS/1  memory request channel
mem_req_data_valid/ready/bits/mask  out/in/out/out  1/1/DATA_BITS/DATA_BITS/8  memory write channel
mem_resp_val  in  1  memory read beat valid
mem_resp_data  in  DATA_BITS  memory read beat
resp_err  out  1  sticky: response beat arrived with no owner

Behaviour:
- Reset (reset=0, async):
  - State IDLE; prio=0 (port 0 favoured).
  - Owner FIFO empty; beat counters 0; resp_err=0.
  - All val/rdy/ready outputs 0. Data outputs are don't-care but driven 0.
- State IDLE, request issue:
  - A requester is eligible when reqN_val=1 and it is not (reqN_rw=0 with owner FIFO full).
  - Winner selection: if both are eligible, the winner is prio; otherwise the single eligible requester.
  - mem_req_val=1 iff a winner exists. mem_req_addr/rw are muxed from the winner.
  - reqN_rdy = mem_req_rdy & (winner==N). Request path is combinational; zero added latency.
- Request fire (mem_req_val&mem_req_rdy):
  - prio <= ~winner.
  - Read: push winner ID into owner FIFO.
  - Write: lock <= winner, wbeat <= 0, go to WDATA.
- State WDATA:
  - mem_req_val=0; both reqN_rdy=0.
  - mem_req_data_valid = lock's data_valid. bits/mask are muxed from lock.
  - lock's data_ready = mem_req_data_ready. The other port's data_ready=0.
  - Each data fire increments wbeat. On the fire where wbeat==BEATS-1, go to IDLE; a new request may issue the next cycle.
- In all other states mem_req_data_valid=0 and both data_ready=0. Requesters may assert data_valid early; it is ignored.
- Response routing (independent of FSM):
  - On mem_resp_val with FIFO non-empty: req[head]_resp_val=1 and resp_data=mem_resp_data, same cycle, combinational. The other port's resp_val=0.
  - rbeat increments per beat. At rbeat==BEATS-1, pop the FIFO and reset rbeat to 0.
  - On mem_resp_val with FIFO empty: drop the beat and set resp_err=1, which stays set until reset.
- Simultaneous push and pop on the same cycle are both honoured; occupancy is unchanged.
- A read may issue to the FIFO when it is full only if a pop occurs the same cycle — not allowed: full blocks the read.
- Writes never need the FIFO and may issue while the FIFO is full.
- Reads may issue while earlier read responses are still streaming. Responses are strictly in request order.
- Reset mid-WDATA or mid-response abandons the transaction. The memory model is reset together with the arbiter.

Test Plan:
- Port 0 read addr 0x10 alone, mem_req_rdy=1 → mem_req_val same cycle, req0_rdy=1; four mem_resp beats A,B,C,D → req0_resp_val four cycles with A..D, req1_resp_val=0; FIFO empty after.
- Both ports read in the same cycle (addr 0x20, 0x40) after reset → port 0 granted first, port 1 next cycle; responses go 4 beats to port 0, then 4 to port 1.
- Port 1 write addr 0x80, data_valid with mem_req_data_ready toggling 1,0,1,1,1 → exactly 4 beats forwarded in order; port 0 read held off (req0_rdy=0) until the cycle after the 4th beat.
- OUTSTANDING=4 reads from port 0 with no responses → 5th read gets req0_rdy=0; a port 1 write issues meanwhile; after the first 4 response beats pop, the 5th read issues.
- mem_resp_val pulse with no outstanding reads → no resp_val on either port, resp_err=1 and stays 1; reset=0 clears it.
- Assert reset during WDATA beat 2 → all outputs 0 immediately (async); after release the state is IDLE and a fresh port 0 read issues normally.
